pc_bimodal: RTL
===============

// Module: pc_bimodal
// PURPOSE
//  Next-PC generator for the fetch stage with a parametrised bimodal branch predictor.
//  - Each cycle it computes the next fetch address from the last fetched PC and instruction.
//  - It redirects fetch on a misbranch from branch-info forwarding.
//  - It trains a table of N-bit saturating counters from resolved branches.
//  - It keeps saturating branch and mispredict statistics counters.
// PARAMETERS
//  INDEX_BITS   6      table depth = 2**INDEX_BITS; index = pc[INDEX_BITS+1:2]
//  CTR_BITS     2      saturating counter width (>=1); predict taken = counter MSB
//  CTR_INIT     1      counter value after reset (weakly not-taken for CTR_BITS=2)
//  PREDICT_EN   1      1 = bimodal prediction; 0 = static not-taken (table still trains)
//  RESET_PC     0      out_next_pc value after reset
//  STAT_BITS    32     width of the statistics counters
// PORTS
//  clk                             in   1     clock, rising edge
//  rst_n                           in   1     asynchronous, active-low reset
//  ena                             in   1     global enable; low = all state frozen
//  in_fetcher_ena                  in   1     fetcher delivered in_last_pc/in_last_inst this cycle
//  in_last_pc                      in   32    PC of the last fetched instruction
//  in_last_inst                    in   32    last fetched instruction
//  out_next_pc                     out  32    registered next fetch address
//  out_next_taken                  out  1     prediction for in_last_inst (combinational)
//  in_misbranch                    in   1     resolved branch was mispredicted
//  in_update_valid                 in   1     a conditional branch resolved this cycle
//  in_forwarding_branch_taken      in   1     resolved direction
//  in_forwarding_branch_pc         in   32    PC of the resolved branch
//  in_forwarding_correct_address   in   32    correct target after a misbranch
//  out_rollback                    out  1     = in_misbranch (combinational); flushes pipeline
//  out_rollback_pc                 out  32    = in_forwarding_branch_pc (combinational)
//  out_branch_count                out  STAT_BITS  resolved branches, saturating
//  out_mispredict_count            out  STAT_BITS  misbranches, saturating
// BEHAVIOUR
//  Reset (rst_n low, asynchronous, any time)
//  - out_next_pc = RESET_PC.
//  - All table entries = CTR_INIT.
//  - Both statistics counters = 0.
//  - Combinational outputs follow their inputs.
//  Immediates
//  - B_IMM = sext{i[31],i[7],i[30:25],i[11:8],0}.
//  - J_IMM = sext{i[31],i[19:12],i[20],i[30:21],0}.
//  - All adds are 32-bit and wrap modulo 2**32.
//  Prediction
//  - out_next_taken = PREDICT_EN && opcode==7'b1100011 && table[idx(in_last_pc)][CTR_BITS-1].
//  - For any other opcode, out_next_taken is 0.
//  Next PC (posedge clk, only when ena=1), in priority order:
//  - 1. in_misbranch -> out_next_pc = in_forwarding_correct_address. Fetch input is ignored this cycle.
//  - 2. in_fetcher_ena with opcode BRANCH -> out_next_taken ? pc+B_IMM : pc+4.
//  - 2. in_fetcher_ena with opcode JAL (7'b1101111) -> pc+J_IMM.
//  - 2. in_fetcher_ena with any other opcode, JALR included -> pc+4. JALR is corrected via misbranch.
//  - 3. Otherwise out_next_pc holds its value.
//  - Latency: 1 cycle from fetch input to out_next_pc.
//  Training (posedge clk, ena=1 and in_update_valid=1)
//  - The entry at idx(in_forwarding_branch_pc) is incremented if taken, decremented if not.
//  - The entry saturates at 2**CTR_BITS-1 and at 0.
//  - Training applies even when in_misbranch=1 in the same cycle.
//  - If the predict index and the update index are equal in the same cycle, prediction uses the pre-update value.
//  Statistics (posedge clk, ena=1)
//  - out_branch_count += in_update_valid.
//  - out_mispredict_count += in_misbranch.
//  - Both hold at all-ones.
//  ena=0: no register, table entry or counter changes, regardless of other inputs.
//  Misbranch and update pulses arriving while ena=0 are lost; the upstream block must hold them.
// TESTING
//  T1 reset: rst_n=0 mid-run, no clock edge -> out_next_pc=0 and counters=0 immediately.
//     After release, PC 0x100 (non-branch) -> 0x104.
//  T2 JAL: pc=0x1000, inst=0x0080006F (J_IMM=+8) -> out_next_pc=0x1008, out_next_taken=0.
//     Negative imm: pc=0x10, inst=0xFF1FF06F (J_IMM=-16) -> 0x0.
//  T3 training: reset, then branch pc=0x40, inst=0x00000463 (B_IMM=+8) -> taken=0, next=0x44.
//     Apply two taken updates at pc 0x40, then repeat the fetch -> taken=1, next=0x48.
//     Apply 3 more taken updates, then 4 not-taken -> entry is 00 (saturation both ends); predict 0.
//  T4 priority: same cycle misbranch (correct=0x2000) plus a fetched JAL plus update at 0x40.
//     -> out_next_pc=0x2000, out_rollback=1, entry trained, mispredict_count=1, branch_count=1.
//  T5 PREDICT_EN=0: train entry to 11 -> out_next_taken stays 0, next=pc+4.
//  T6 ena=0 for 5 cycles with fetch, misbranch and update pulses -> no state change.
//     STAT_BITS=4, 20 misbranches with ena=1 -> mispredict_count saturates at 15.

Source files
------------

// File: rtl/pc_bimodal_if.sv
// ----------------------------------------------------------------------------
// pc_bimodal_if
//   Bundles the fetch, branch-forwarding and statistics signals of the
//   next-PC generator.
//   master : drives enable, fetch and forwarding inputs, observes results
//   slave  : the pc_bimodal block itself
//   Signals:
//     ena                            global enable (low freezes all state)
//     in_fetcher_ena                 in_last_pc/in_last_inst valid this cycle
//     in_last_pc, in_last_inst       last fetched PC and instruction
//     out_next_pc                    registered next fetch address
//     out_next_taken                 combinational prediction for in_last_inst
//     in_misbranch                   resolved branch was mispredicted
//     in_update_valid                a conditional branch resolved this cycle
//     in_forwarding_branch_taken     resolved direction
//     in_forwarding_branch_pc        PC of the resolved branch
//     in_forwarding_correct_address  redirect target after a misbranch
//     out_rollback, out_rollback_pc  pipeline flush request and its PC
//     out_branch_count               saturating count of resolved branches
//     out_mispredict_count           saturating count of misbranches
// ----------------------------------------------------------------------------
interface pc_bimodal_if #(
  parameter int STAT_BITS = 32
);
  logic                 ena;
  logic                 in_fetcher_ena;
  logic [31:0]          in_last_pc;
  logic [31:0]          in_last_inst;
  logic [31:0]          out_next_pc;
  logic                 out_next_taken;
  logic                 in_misbranch;
  logic                 in_update_valid;
  logic                 in_forwarding_branch_taken;
  logic [31:0]          in_forwarding_branch_pc;
  logic [31:0]          in_forwarding_correct_address;
  logic                 out_rollback;
  logic [31:0]          out_rollback_pc;
  logic [STAT_BITS-1:0] out_branch_count;
  logic [STAT_BITS-1:0] out_mispredict_count;

  modport master (
    output ena, in_fetcher_ena, in_last_pc, in_last_inst,
           in_misbranch, in_update_valid, in_forwarding_branch_taken,
           in_forwarding_branch_pc, in_forwarding_correct_address,
    input  out_next_pc, out_next_taken, out_rollback, out_rollback_pc,
           out_branch_count, out_mispredict_count
  );

  modport slave (
    input  ena, in_fetcher_ena, in_last_pc, in_last_inst,
           in_misbranch, in_update_valid, in_forwarding_branch_taken,
           in_forwarding_branch_pc, in_forwarding_correct_address,
    output out_next_pc, out_next_taken, out_rollback, out_rollback_pc,
           out_branch_count, out_mispredict_count
  );
endinterface

// File: rtl/pc_bimodal.sv
// ----------------------------------------------------------------------------
// pc_bimodal
//   Next-PC generator for the fetch stage with a bimodal branch predictor.
//   Computes the next fetch address from the last fetched PC/instruction,
//   redirects on a misbranch, trains a table of saturating counters from
//   resolved branches and keeps saturating branch/mispredict statistics.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    pc_bimodal_if.slave (fetch, forwarding, statistics signals)
//   The STAT_BITS parameter must match the interface instance's STAT_BITS.
// ----------------------------------------------------------------------------
module pc_bimodal #(
  parameter int          INDEX_BITS = 6,
  parameter int          CTR_BITS   = 2,
  parameter int          CTR_INIT   = 1,
  parameter int          PREDICT_EN = 1,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          STAT_BITS  = 32
) (
  input logic         clk,
  input logic         rst_n,
  pc_bimodal_if.slave bus
);

  localparam int                DEPTH      = 1 << INDEX_BITS;
  localparam logic [6:0]        OP_BRANCH  = 7'b1100011;
  localparam logic [6:0]        OP_JAL     = 7'b1101111;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(CTR_INIT);

  logic [CTR_BITS-1:0]   table_q [DEPTH];
  logic [31:0]           pc_q, pc_d;
  logic [STAT_BITS-1:0]  branch_q, mispredict_q;

  logic [INDEX_BITS-1:0] pred_idx, upd_idx;
  logic [6:0]            opcode;
  logic [31:0]           b_imm, j_imm;
  logic                  is_branch, taken;
  logic [CTR_BITS-1:0]   upd_val;

  // --------------------------------------------------------------------------
  // Decode and prediction
  // --------------------------------------------------------------------------
  assign pred_idx  = bus.in_last_pc[INDEX_BITS+1:2];
  assign upd_idx   = bus.in_forwarding_branch_pc[INDEX_BITS+1:2];
  assign opcode    = bus.in_last_inst[6:0];
  assign is_branch = (opcode == OP_BRANCH);

  assign b_imm = {{19{bus.in_last_inst[31]}}, bus.in_last_inst[31], bus.in_last_inst[7],
                  bus.in_last_inst[30:25], bus.in_last_inst[11:8], 1'b0};
  assign j_imm = {{11{bus.in_last_inst[31]}}, bus.in_last_inst[31], bus.in_last_inst[19:12],
                  bus.in_last_inst[20], bus.in_last_inst[30:21], 1'b0};

  // Reads the registered table, so a same-cycle update at this index is not
  // yet visible: prediction uses the pre-update counter.
  assign taken = (PREDICT_EN != 0) && is_branch && table_q[pred_idx][CTR_BITS-1];

  assign bus.out_next_taken  = taken;
  assign bus.out_rollback    = bus.in_misbranch;
  assign bus.out_rollback_pc = bus.in_forwarding_branch_pc;

  // --------------------------------------------------------------------------
  // Next-PC selection: misbranch redirect wins over the fetched instruction.
  // JALR falls through to pc+4 and is repaired later by a misbranch.
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pc_d = pc_q;
    if (bus.in_misbranch) begin
      pc_d = bus.in_forwarding_correct_address;
    end else if (bus.in_fetcher_ena) begin
      if (is_branch)             pc_d = taken ? bus.in_last_pc + b_imm : bus.in_last_pc + 32'd4;
      else if (opcode == OP_JAL) pc_d = bus.in_last_pc + j_imm;
      else                       pc_d = bus.in_last_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of block ordering.
    if (!rst_n)       pc_q <= RESET_PC;
    else if (bus.ena) pc_q <= pc_d;
  end

  assign bus.out_next_pc = pc_q;

  // --------------------------------------------------------------------------
  // Counter training with saturation at both ends
  // --------------------------------------------------------------------------
  always_comb begin
    upd_val = table_q[upd_idx];
    if (bus.in_forwarding_branch_taken) begin
      if (upd_val != CTR_MAX) upd_val = upd_val + CTR_BITS'(1);
    end else begin
      if (upd_val != '0)      upd_val = upd_val - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is built from flops rather than a RAM macro precisely
      // because every entry must return to CTR_INIT on reset.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_RST;
    end else if (bus.ena && bus.in_update_valid) begin
      table_q[upd_idx] <= upd_val;
    end
  end

  // --------------------------------------------------------------------------
  // Saturating statistics
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_q     <= '0;
      mispredict_q <= '0;
    end else if (bus.ena) begin
      if (bus.in_update_valid && !(&branch_q))  branch_q     <= branch_q + STAT_BITS'(1);
      if (bus.in_misbranch && !(&mispredict_q)) mispredict_q <= mispredict_q + STAT_BITS'(1);
    end
  end

  assign bus.out_branch_count     = branch_q;
  assign bus.out_mispredict_count = mispredict_q;

endmodule
